// File: rtl/collision_engine_if.sv
// Frame handshake and result bus between game logic and collision_engine.
// Wall coordinates are packed flat, wall i at [i*COORD_W +: COORD_W].
interface collision_engine_if #(
    parameter int N_WALLS = 4,
    parameter int COORD_W = 9,
    parameter int SCORE_W = 8,
    parameter int IDX_W   = (N_WALLS > 1) ? $clog2(N_WALLS) : 1
);
    logic                         start;
    logic                         clear;
    logic [COORD_W-1:0]           bird_x;
    logic [COORD_W-1:0]           bird_y;
    logic [N_WALLS*COORD_W-1:0]   wall_x;
    logic [N_WALLS*COORD_W-1:0]   wall_gap_y;
    logic [N_WALLS-1:0]           wall_en;
    logic                         busy;
    logic                         done;
    logic                         hit;
    logic [IDX_W-1:0]             hit_wall;
    logic                         hit_floor;
    logic                         score_pulse;
    logic [SCORE_W-1:0]           score;

    modport master (
        output start, clear, bird_x, bird_y, wall_x, wall_gap_y, wall_en,
        input  busy, done, hit, hit_wall, hit_floor, score_pulse, score
    );

    modport slave (
        input  start, clear, bird_x, bird_y, wall_x, wall_gap_y, wall_en,
        output busy, done, hit, hit_wall, hit_floor, score_pulse, score
    );
endinterface

// File: rtl/collision_engine.sv
// Sequential multi-wall collision and scoring engine: snapshots one frame of
// positions on start, then evaluates one wall per clock (IDLE -> CHECK -> DONE).
module collision_engine #(
    parameter int N_WALLS  = 4,
    parameter int COORD_W  = 9,
    parameter int BIRD_W   = 10,
    parameter int BIRD_H   = 10,
    parameter int WALL_W   = 20,
    parameter int GAP_H    = 60,
    parameter int SCREEN_H = 240,
    parameter int SCORE_W  = 8,
    parameter int IDX_W    = (N_WALLS > 1) ? $clog2(N_WALLS) : 1
) (
    input logic               clk,
    input logic               reset,
    collision_engine_if.slave bus
);
    // Two guard bits so right/bottom edge sums never wrap.
    localparam int AW = COORD_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WALLS - 1);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
    state_t state, state_d;

    logic [IDX_W-1:0]                 idx;
    logic [COORD_W-1:0]               snap_bx, snap_by;
    logic [N_WALLS-1:0][COORD_W-1:0]  snap_wx, snap_gy;
    logic [N_WALLS-1:0]               snap_en;
    logic [N_WALLS-1:0]               passed, passed_d;
    logic                             hit, hit_d, hit_base;
    logic                             hit_floor, hit_floor_d;
    logic [IDX_W-1:0]                 hit_wall, hit_wall_d;
    logic                             score_pulse, pass_now;
    logic [SCORE_W-1:0]               score, score_d;

    logic [AW-1:0] bx, by, wx, gy;
    logic          in_check, cur_en, xov, yout, wall_hit, behind, floor_hit;

    assign bx       = AW'(snap_bx);
    assign by       = AW'(snap_by);
    assign wx       = AW'(snap_wx[idx]);
    assign gy       = AW'(snap_gy[idx]);
    assign cur_en   = snap_en[idx];
    assign in_check = (state == CHECK);

    assign xov       = (bx + AW'(BIRD_W - 1) >= wx) && (bx <= wx + AW'(WALL_W - 1));
    assign yout      = (by < gy) || (by + AW'(BIRD_H) > gy + AW'(GAP_H));
    assign wall_hit  = in_check && cur_en && xov && yout;
    assign behind    = (wx + AW'(WALL_W - 1)) < bx;
    assign floor_hit = in_check && (idx == '0) &&
                       ((by + AW'(BIRD_H) > AW'(SCREEN_H)) || (by == '0));

    always_comb begin
        state_d  = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) state_d = CHECK;
            CHECK: begin
                bus.busy = 1'b1;
                if (idx == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // clear is applied first, so a same-cycle collision or pass lands on top of it.
    always_comb begin
        hit_base    = hit & ~bus.clear;
        hit_d       = hit_base | wall_hit | floor_hit;
        hit_wall_d  = bus.clear ? '0 : hit_wall;
        if (wall_hit && !hit_base) hit_wall_d = idx;
        hit_floor_d = (hit_floor & ~bus.clear) | floor_hit;
        passed_d    = bus.clear ? '0 : passed;
        score_d     = bus.clear ? '0 : score;
        pass_now    = 1'b0;
        if (in_check && cur_en) begin
            if (behind) begin
                if (!passed_d[idx]) begin
                    passed_d[idx] = 1'b1;
                    pass_now      = 1'b1;
                    if (score_d != '1) score_d = score_d + 1'b1;
                end
            end else begin
                passed_d[idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            snap_bx     <= '0;
            snap_by     <= '0;
            snap_wx     <= '0;
            snap_gy     <= '0;
            snap_en     <= '0;
            passed      <= '0;
            hit         <= 1'b0;
            hit_wall    <= '0;
            hit_floor   <= 1'b0;
            score_pulse <= 1'b0;
            score       <= '0;
        end else begin
            state       <= state_d;
            passed      <= passed_d;
            hit         <= hit_d;
            hit_wall    <= hit_wall_d;
            hit_floor   <= hit_floor_d;
            score_pulse <= pass_now;
            score       <= score_d;
            if (state == IDLE) begin
                idx <= '0;
                if (bus.start) begin
                    snap_bx <= bus.bird_x;
                    snap_by <= bus.bird_y;
                    snap_wx <= bus.wall_x;
                    snap_gy <= bus.wall_gap_y;
                    snap_en <= bus.wall_en;
                end
            end else if (state == CHECK) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.hit         = hit;
    assign bus.hit_wall    = hit_wall;
    assign bus.hit_floor   = hit_floor;
    assign bus.score_pulse = score_pulse;
    assign bus.score       = score;
endmodule

// File: tb/tb_collision_engine.sv
// Scoreboard bench for collision_engine: frames push expected results, an
// independent monitor pops and compares on every done pulse.
module tb_collision_engine;
    localparam int N  = 4;
    localparam int CW = 9;
    localparam int SW = 8;
    localparam int BIRD_W = 10, BIRD_H = 10, WALL_W = 20, GAP_H = 60, SCREEN_H = 240;

    logic clk, reset;
    longint cyc = 0;
    int errors = 0;
    int checks = 0;

    collision_engine_if #(.N_WALLS(N), .COORD_W(CW), .SCORE_W(SW)) bus_if ();

    collision_engine #(
        .N_WALLS(N), .COORD_W(CW), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
        .WALL_W(WALL_W), .GAP_H(GAP_H), .SCREEN_H(SCREEN_H), .SCORE_W(SW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     hit;
        int     hw;
        int     hf;
        int     score;
        int     pulses;
        longint done_cyc;
    } exp_t;
    exp_t sbq[$];

    // Reference game state
    int m_hit, m_hw, m_hf, m_score;
    bit m_passed[N];
    int wx[N];
    int gy[N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        m_hit = 0; m_hw = 0; m_hf = 0; m_score = 0;
        for (int i = 0; i < N; i++) m_passed[i] = 0;
    endfunction

    // One frame: model the outcome, drive start, optionally pulse clear during
    // wall clear_at's evaluation, re-pulse start at cycle restart_at, probe hit at probe_k.
    task automatic frame(input int bx, input int by, input bit [N-1:0] en,
                         input int clear_at, input int restart_at,
                         input int probe_k, input int probe_hit, input int probe_hf);
        exp_t e;
        int   pulses = 0;
        bit   seen = 0;
        for (int i = 0; i < N; i++) begin
            if (i == clear_at) model_clear();
            if (i == 0 && (by + BIRD_H > SCREEN_H || by == 0)) begin
                m_hit = 1; m_hf = 1;
            end
            if (en[i]) begin
                if (bx + BIRD_W - 1 >= wx[i] && bx <= wx[i] + WALL_W - 1 &&
                    (by < gy[i] || by + BIRD_H > gy[i] + GAP_H)) begin
                    if (m_hit == 0) m_hw = i;
                    m_hit = 1;
                end
                if (wx[i] + WALL_W - 1 < bx) begin
                    if (!m_passed[i]) begin
                        m_passed[i] = 1;
                        pulses++;
                        if (m_score < 255) m_score++;
                    end
                end else begin
                    m_passed[i] = 0;
                end
            end
        end
        @(negedge clk);
        bus_if.bird_x  = CW'(bx);
        bus_if.bird_y  = CW'(by);
        bus_if.wall_en = en;
        for (int i = 0; i < N; i++) begin
            bus_if.wall_x[i*CW +: CW]     = CW'(wx[i]);
            bus_if.wall_gap_y[i*CW +: CW] = CW'(gy[i]);
        end
        bus_if.start = 1'b1;
        e.hit = m_hit; e.hw = m_hw; e.hf = m_hf; e.score = m_score;
        e.pulses = pulses; e.done_cyc = cyc + N + 1;
        sbq.push_back(e);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus_if.start = (k == restart_at);
            bus_if.clear = (clear_at >= 0) && (k == clear_at + 1);
            if (k == probe_k) begin
                chk("probe_hit", bus_if.hit, probe_hit);
                chk("probe_hit_floor", bus_if.hit_floor, probe_hf);
            end
            if (bus_if.done) begin
                seen = 1;
                break;
            end
        end
        bus_if.start = 1'b0;
        bus_if.clear = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus_if.clear = 1'b1;
        @(negedge clk);
        bus_if.clear = 1'b0;
        model_clear();
    endtask

    task automatic set_walls(input int x, input int g);
        for (int i = 0; i < N; i++) begin
            wx[i] = x; gy[i] = g;
        end
    endtask

    // Monitor: compares every completed frame against the queued expectation.
    initial begin
        int   pcount = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pcount = 0;
            end else begin
                if (bus_if.score_pulse) pcount++;
                if (bus_if.done) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("busy_at_done", bus_if.busy, 1);
                        chk("hit", bus_if.hit, e.hit);
                        chk("hit_wall", bus_if.hit_wall, e.hw);
                        chk("hit_floor", bus_if.hit_floor, e.hf);
                        chk("score", bus_if.score, e.score);
                        chk("score_pulses", pcount, e.pulses);
                    end
                    pcount = 0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus_if.start = 1'b0; bus_if.clear = 1'b0;
        bus_if.bird_x = '0; bus_if.bird_y = '0;
        bus_if.wall_x = '0; bus_if.wall_gap_y = '0; bus_if.wall_en = '0;
        model_clear();
        set_walls(0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_done", bus_if.done, 0);
        chk("rst_hit", bus_if.hit, 0);
        chk("rst_hit_wall", bus_if.hit_wall, 0);
        chk("rst_hit_floor", bus_if.hit_floor, 0);
        chk("rst_score_pulse", bus_if.score_pulse, 0);
        chk("rst_score", bus_if.score, 0);

        // Bird inside the gap, then top-edge collision which stays sticky
        wx = '{45, 0, 0, 0}; gy = '{90, 0, 0, 0};
        frame(50, 100, 4'b0001, -1, 0, 2, 0, 0);
        gy[0] = 105;
        frame(50, 100, 4'b0001, -1, 0, 2, 1, 0);
        gy[0] = 90;
        frame(50, 100, 4'b0001, -1, 0, 0, 0, 0);

        // First hit wins, then wall3 alone after clear
        do_clear();
        wx = '{200, 45, 200, 45}; gy = '{105, 105, 105, 105};
        frame(50, 100, 4'b1010, -1, 0, 0, 0, 0);
        do_clear();
        frame(50, 100, 4'b1000, -1, 0, 0, 0, 0);

        // Floor hit at y=231, none at y=230
        do_clear();
        frame(50, 231, 4'b0000, -1, 0, 2, 1, 1);
        do_clear();
        frame(50, 230, 4'b0000, -1, 0, 2, 0, 0);

        // Scoring sequence
        do_clear();
        wx = '{31, 300, 300, 300}; gy = '{90, 90, 90, 90};
        frame(50, 100, 4'b0001, -1, 0, 0, 0, 0);
        wx[0] = 29;  frame(50, 100, 4'b0001, -1, 0, 0, 0, 0);
        wx[0] = 27;  frame(50, 100, 4'b0001, -1, 0, 0, 0, 0);
        wx[0] = 300; frame(50, 100, 4'b0001, -1, 0, 0, 0, 0);
        wx[0] = 29;  frame(50, 100, 4'b0001, -1, 0, 0, 0, 0);
        chk("score_after_two_passes", bus_if.score, 2);

        // Clear in the same cycle as a collision
        do_clear();
        wx = '{300, 45, 45, 300}; gy = '{105, 105, 105, 105};
        frame(50, 100, 4'b0010, -1, 0, 0, 0, 0);
        frame(50, 100, 4'b0100, 2, 0, 0, 0, 0);

        // start while busy is ignored
        frame(50, 100, 4'b0100, -1, 2, 0, 0, 0);

        // Reset in cycle 2 of a check aborts and clears passed bits
        do_clear();
        wx = '{29, 300, 300, 300}; gy = '{90, 90, 90, 90};
        frame(50, 100, 4'b0001, -1, 0, 0, 0, 0);
        @(negedge clk);
        bus_if.bird_x = CW'(50); bus_if.bird_y = '0; bus_if.wall_en = '0;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        chk("pre_abort_hit", bus_if.hit, 1);
        chk("pre_abort_score", bus_if.score, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", bus_if.busy, 0);
        chk("abort_done", bus_if.done, 0);
        chk("abort_hit", bus_if.hit, 0);
        chk("abort_hit_floor", bus_if.hit_floor, 0);
        chk("abort_score", bus_if.score, 0);
        model_clear();
        frame(50, 100, 4'b0001, -1, 0, 0, 0, 0);

        // Score saturation: four walls alternate behind/ahead
        do_clear();
        for (int r = 0; r < 66; r++) begin
            set_walls(50, 80);  frame(100, 100, 4'b1111, -1, 0, 0, 0, 0);
            set_walls(300, 80); frame(100, 100, 4'b1111, -1, 0, 0, 0, 0);
        end
        chk("score_saturated", bus_if.score, 255);

        // Randomized frames
        do_clear();
        for (int r = 0; r < 120; r++) begin
            int bx, by;
            bx = int'($urandom_range(20, 120));
            by = int'($urandom_range(0, 235));
            for (int i = 0; i < N; i++) begin
                wx[i] = int'($urandom_range(0, 200));
                gy[i] = int'($urandom_range(0, 190));
            end
            if ($urandom_range(0, 5) == 0) do_clear();
            frame(bx, by, 4'($urandom), -1, 0, 0, 0, 0);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/collision_engine.md
# collision_engine

Sequential, multi-wall collision and scoring engine for the side-scrolling bird game. Once per frame it snapshots the bird position and up to N_WALLS wall positions, then checks one wall per clock for bounding-box overlap with the wall body outside its gap. It also checks the floor and ceiling and detects wall passes for scoring. It sits between the position/movement logic and the game-control FSM, and replaces the single-wall combinational checker.

## Interface
- N_WALLS, 4, number of wall channels checked per frame
- COORD_W, 9, width of every x/y coordinate (unsigned pixels)
- BIRD_W, 10, bird width in pixels
- BIRD_H, 10, bird height in pixels
- WALL_W, 20, wall width in pixels
- GAP_H, 60, vertical gap height in pixels
- SCREEN_H, 240, playfield height; y = 0 is the top
- SCORE_W, 8, score counter width
- IDX_W is derived as max(1, clog2(N_WALLS))

- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame check
- clear  in  1  clears the sticky hit, hit_wall and hit_floor; zeroes the score and all passed bits
- bird_x, bird_y  in  COORD_W each  top-left corner of the bird
- wall_x  in  N_WALLS*COORD_W  left edge of wall i, at bits [i*COORD_W +: COORD_W]
- wall_gap_y  in  N_WALLS*COORD_W  top of the gap of wall i, packed the same way
- wall_en  in  N_WALLS  wall i takes part only when its bit is 1
- busy  out  1  high while a check is in progress
- done  out  1  one-cycle pulse when a frame check completes
- hit  out  1  sticky; set on any wall, floor or ceiling collision
- hit_wall  out  IDX_W  index of the first wall that hit since the last clear
- hit_floor  out  1  sticky; set by a floor or ceiling collision
- score_pulse  out  1  one-cycle pulse per wall pass
- score  out  SCORE_W  count of passes; saturates at all-ones

## Operation
- FSM states are IDLE, CHECK and DONE.
- IDLE: on start, capture bird_x, bird_y, wall_x, wall_gap_y and wall_en into snapshot registers, set idx = 0 and go to CHECK.
- start while busy is ignored. Inputs are never read outside the start cycle.
- CHECK, one wall per cycle, all arithmetic at COORD_W+2 bits with no wrap:
  - xov = (bird_x + BIRD_W - 1 >= wall_x) AND (bird_x <= wall_x + WALL_W - 1).
  - yout = (bird_y < gap_y) OR (bird_y + BIRD_H > gap_y + GAP_H).
  - wall i collides when wall_en[i], xov and yout are all true.
  - On a collision with hit already 0: hit <= 1 and hit_wall <= i.
  - On a collision with hit already 1: hit_wall is unchanged (first hit wins).
- Pass detection, evaluated per wall in the same CHECK cycle, only when wall_en[i] = 1:
  - Wall is behind the bird when wall_x + WALL_W - 1 < bird_x.
  - If behind and passed[i] = 0: set passed[i] and pulse score_pulse; score increments unless saturated.
  - If not behind: clear passed[i] (wall has respawned to the right).
- The floor/ceiling test runs in the first CHECK cycle: bird_y + BIRD_H > SCREEN_H, or bird_y = 0, sets hit and hit_floor.
- CHECK advances idx each cycle. After idx = N_WALLS-1 it goes to DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- clear is accepted in any state.
  - If a collision is detected in the same cycle as clear, the collision wins: hit = 1 and hit_wall is the new index.
  - If a pass occurs in the same cycle as clear, score = 1.
- reset mid-check aborts the frame immediately and returns to IDLE.

## Timing
- Reset values: FSM in IDLE; busy, done, hit, hit_floor and score_pulse = 0; hit_wall = 0; score = 0; all passed bits = 0.
- Cycle 0: start sampled. Cycles 1..N_WALLS: CHECK. busy = 1 from cycle 1 through cycle N_WALLS+1.
- Cycle N_WALLS+1: done = 1. The next start is accepted from cycle N_WALLS+2.
- Result for wall i is evaluated in cycle 1+i and is registered on the outputs in cycle 2+i. hit_floor appears in cycle 2.
- Frame latency from start to done is N_WALLS+1 cycles.
- score_pulse goes high at most once per wall per frame, in the cycle after that wall's evaluation. score updates in the same cycle as score_pulse.

## Test plan
- Bird inside the gap: bird (50,100); wall0 x=45, gap_y=90; other walls disabled; start → done at cycle 5, hit = 0, score_pulse never high.
- Top-edge collision: same as above with gap_y=105 → hit = 1 and hit_wall = 0 in cycle 2; hit stays 1 across later frames until clear.
- First hit wins: wall1 and wall3 both colliding → hit_wall = 1. Pulse clear, rerun with wall3 alone → hit_wall = 3.
- Floor hit: bird_y=231 with BIRD_H=10 → hit = 1 and hit_floor = 1 in cycle 2. Repeat with bird_y=230 → no hit.
- Scoring sequence, bird_x=50:
  - wall0 x=31 → no pulse.
  - next frame x=29 → score_pulse, score = 1.
  - next frame x=27 → no pulse.
  - respawn x=300, then x=29 → score = 2.
  - force score to 255, then another pass → score stays 255.
- Abort and corner cases:
  - reset asserted in cycle 2 of a check → next cycle busy = 0 and all outputs at reset values.
  - start pulsed while busy → ignored, done pulses exactly once.
  - clear in the same cycle as a collision → hit = 1.
